// File: rtl/monolith_axis_chunk_fifo.sv
// AXI4-Stream sink that packs words into a ring of fixed-size chunks and
// presents the oldest committed chunk, all words in parallel, with valid/ready.
module monolith_axis_chunk_fifo #(
  parameter int CHUNK_SIZE           = 16,
  parameter int CHUNK_COUNT          = 2,
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int CLOSE_ON_TLAST       = 1
) (
  input  logic                                  S_AXIS_ACLK,
  input  logic                                  S_AXIS_ARESET,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]       S_AXIS_TDATA,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]     S_AXIS_TSTRB,
  input  logic                                  S_AXIS_TLAST,
  input  logic                                  S_AXIS_TVALID,
  output logic                                  S_AXIS_TREADY,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]       chunk_out [0:CHUNK_SIZE-1],
  output logic                                  chunk_valid,
  input  logic                                  chunk_ready,
  output logic                                  chunk_last,
  output logic [$clog2(CHUNK_SIZE):0]           chunk_words,
  output logic [$clog2(CHUNK_COUNT):0]          chunk_count
);

  localparam int IW = $clog2(CHUNK_SIZE);
  localparam int CW = $clog2(CHUNK_COUNT);
  localparam int SW = C_S_AXIS_TDATA_WIDTH / 8;
  localparam logic [IW-1:0] IDX_LAST   = IW'(CHUNK_SIZE - 1);
  localparam logic [CW:0]   COUNT_FULL = (CW+1)'(CHUNK_COUNT);
  localparam logic [CW:0]   COUNT_TWO  = (CW+1)'(2);

  logic [C_S_AXIS_TDATA_WIDTH-1:0] mem [CHUNK_COUNT][CHUNK_SIZE];
  logic [IW:0]                     mem_words [CHUNK_COUNT];
  logic                            mem_last  [CHUNK_COUNT];

  logic [CW-1:0] wr_chunk;
  logic [CW-1:0] rd_chunk;
  logic [IW-1:0] wr_idx;
  logic [CW:0]   count;

  logic                            handshake;
  logic                            commit;
  logic                            consume;
  logic                            load;
  logic                            load_next;
  logic [CW-1:0]                   load_slot;
  logic [C_S_AXIS_TDATA_WIDTH-1:0] wdata;

  assign S_AXIS_TREADY = (count < COUNT_FULL);
  assign chunk_count   = count;

  assign handshake = S_AXIS_TVALID && S_AXIS_TREADY;
  assign commit    = handshake &&
                     ((wr_idx == IDX_LAST) || ((CLOSE_ON_TLAST != 0) && S_AXIS_TLAST));
  assign consume   = chunk_valid && chunk_ready;
  // On a consume with another committed chunk behind the head, refill on the same edge.
  assign load_next = consume && (count >= COUNT_TWO);
  assign load      = load_next || (!chunk_valid && (count != '0));
  assign load_slot = load_next ? rd_chunk + CW'(1) : rd_chunk;

  always_comb begin
    wdata = '0;
    for (int unsigned b = 0; b < SW; b++) begin
      if (S_AXIS_TSTRB[b]) wdata[b*8 +: 8] = S_AXIS_TDATA[b*8 +: 8];
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (handshake) begin
      mem[wr_chunk][wr_idx] <= wdata;
      if (commit) begin
        mem_words[wr_chunk] <= {1'b0, wr_idx} + (IW+1)'(1);
        mem_last[wr_chunk]  <= S_AXIS_TLAST;
      end
    end
  end

  always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
    if (S_AXIS_ARESET) begin
      wr_chunk    <= '0;
      rd_chunk    <= '0;
      wr_idx      <= '0;
      count       <= '0;
      chunk_valid <= 1'b0;
      chunk_last  <= 1'b0;
      chunk_words <= '0;
      for (int unsigned i = 0; i < CHUNK_SIZE; i++) chunk_out[i] <= '0;
    end else begin
      if (handshake) begin
        if (commit) begin
          wr_idx   <= '0;
          wr_chunk <= wr_chunk + CW'(1);
        end else begin
          wr_idx <= wr_idx + IW'(1);
        end
      end

      if (commit && !consume)      count <= count + (CW+1)'(1);
      else if (!commit && consume) count <= count - (CW+1)'(1);

      if (consume) rd_chunk <= rd_chunk + CW'(1);

      if (load) begin
        chunk_valid <= 1'b1;
        chunk_words <= mem_words[load_slot];
        chunk_last  <= mem_last[load_slot];
        for (int unsigned i = 0; i < CHUNK_SIZE; i++) begin
          chunk_out[i] <= ((IW+1)'(i) < mem_words[load_slot]) ? mem[load_slot][i] : '0;
        end
      end else if (consume) begin
        chunk_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_monolith_axis_chunk_fifo.sv
// Directed bench for monolith_axis_chunk_fifo at default parameters.
module tb_monolith_axis_chunk_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] tdata = '0;
  logic [3:0]  tstrb = 4'hF;
  logic        tlast = 1'b0;
  logic        tvalid = 1'b0;
  logic        tready;
  logic [31:0] chunk_out [0:15];
  logic        chunk_valid;
  logic        chunk_ready = 1'b0;
  logic        chunk_last;
  logic [4:0]  chunk_words;
  logic [1:0]  chunk_count;

  int n_cmp = 0;
  int n_err = 0;

  monolith_axis_chunk_fifo #(
    .CHUNK_SIZE(16),
    .CHUNK_COUNT(2),
    .C_S_AXIS_TDATA_WIDTH(32),
    .CLOSE_ON_TLAST(1)
  ) dut (
    .S_AXIS_ACLK(clk),
    .S_AXIS_ARESET(rst),
    .S_AXIS_TDATA(tdata),
    .S_AXIS_TSTRB(tstrb),
    .S_AXIS_TLAST(tlast),
    .S_AXIS_TVALID(tvalid),
    .S_AXIS_TREADY(tready),
    .chunk_out(chunk_out),
    .chunk_valid(chunk_valid),
    .chunk_ready(chunk_ready),
    .chunk_last(chunk_last),
    .chunk_words(chunk_words),
    .chunk_count(chunk_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves TVALID high so consecutive calls stream without a bubble.
  task automatic send_word(input logic [31:0] d, input logic [3:0] s, input logic l);
    int budget;
    tdata  = d;
    tstrb  = s;
    tlast  = l;
    tvalid = 1'b1;
    budget = 0;
    while (!tready && budget < 100) begin
      tick();
      budget++;
    end
    if (!tready) check("tready_wait", 32'(tready), 32'd1);
    tick();
    tlast = 1'b0;
  endtask

  task automatic idle();
    tvalid = 1'b0;
    tlast  = 1'b0;
    tstrb  = 4'hF;
  endtask

  task automatic consume_pulse();
    chunk_ready = 1'b1;
    tick();
    chunk_ready = 1'b0;
  endtask

  task automatic check_chunk(input string tag, input logic [31:0] base,
                             input int words, input logic last);
    check({tag, "_valid"}, 32'(chunk_valid), 32'd1);
    check({tag, "_words"}, 32'(chunk_words), 32'(words));
    check({tag, "_last"},  32'(chunk_last),  32'(last));
    for (int k = 0; k < 16; k++) begin
      check({tag, "_data"}, chunk_out[k], (k < words) ? base + 32'(k) : 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state while reset is held.
    #3;
    check("rst_valid", 32'(chunk_valid), 32'd0);
    check("rst_count", 32'(chunk_count), 32'd0);
    check("rst_words", 32'(chunk_words), 32'd0);
    check("rst_last",  32'(chunk_last),  32'd0);
    check("rst_data0", chunk_out[0], 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("rst_tready", 32'(tready), 32'd1);

    // 32-word burst, no consumer: no bubbles, first chunk {0..15}.
    for (int i = 0; i < 32; i++) begin
      tdata = 32'(i); tvalid = 1'b1;
      #0;
      check("tready_burst", 32'(tready), 32'd1);
      send_word(32'(i), 4'hF, 1'b0);
    end
    check("full_count", 32'(chunk_count), 32'd2);
    check("full_tready", 32'(tready), 32'd0);
    check_chunk("first", 32'd0, 16, 1'b0);

    // Word 32 stalls while full; one consume re-opens TREADY.
    tdata = 32'd32; tvalid = 1'b1;
    tick();
    check("stall_tready", 32'(tready), 32'd0);
    tick();
    check("stall_count", 32'(chunk_count), 32'd2);
    consume_pulse();
    check("reopen_tready", 32'(tready), 32'd1);
    check("reopen_count", 32'(chunk_count), 32'd1);
    check_chunk("second", 32'd16, 16, 1'b0);
    for (int i = 32; i < 48; i++) send_word(32'(i), 4'hF, 1'b0);
    idle();
    check("wrap_count", 32'(chunk_count), 32'd2);
    consume_pulse();
    check_chunk("wrap", 32'd32, 16, 1'b0);
    consume_pulse();
    check("drain_valid", 32'(chunk_valid), 32'd0);
    check("drain_count", 32'(chunk_count), 32'd0);

    // Short packet closed by TLAST, followed by single-word packet.
    for (int i = 0; i < 5; i++) send_word(32'hA0 + 32'(i), 4'hF, i == 4);
    send_word(32'hB0, 4'hF, 1'b1);
    idle();
    check("tlast_count", 32'(chunk_count), 32'd2);
    check_chunk("tlast", 32'hA0, 5, 1'b1);
    consume_pulse();
    check_chunk("after_tlast", 32'hB0, 1, 1'b1);
    consume_pulse();

    // Byte strobes zero the unqualified lanes.
    send_word(32'hDEADBEEF, 4'b0101, 1'b1);
    idle();
    tick();
    check("strb_data", chunk_out[0], 32'h00AD00EF);
    check("strb_words", 32'(chunk_words), 32'd1);
    consume_pulse();

    // TLAST on the final index commits exactly once.
    for (int i = 0; i < 16; i++) send_word(32'h50 + 32'(i), 4'hF, i == 15);
    idle();
    tick();
    check_chunk("tlast_full", 32'h50, 16, 1'b1);
    check("tlast_full_count", 32'(chunk_count), 32'd1);
    tick();
    check("tlast_once_count", 32'(chunk_count), 32'd1);
    consume_pulse();
    check("tlast_full_drain", 32'(chunk_count), 32'd0);

    // Back-to-back drain with ready held high.
    for (int i = 0; i < 32; i++) send_word(32'h100 + 32'(i), 4'hF, 1'b0);
    idle();
    check("b2b_pre_count", 32'(chunk_count), 32'd2);
    chunk_ready = 1'b1;
    tick();
    check("b2b_valid_held", 32'(chunk_valid), 32'd1);
    check("b2b_count1", 32'(chunk_count), 32'd1);
    check("b2b_head", chunk_out[0], 32'h110);
    tick();
    check("b2b_valid_end", 32'(chunk_valid), 32'd0);
    check("b2b_count0", 32'(chunk_count), 32'd0);
    chunk_ready = 1'b0;

    // Commit and consume on the same edge keep the count.
    for (int i = 0; i < 16; i++) send_word(32'h120 + 32'(i), 4'hF, 1'b0);
    for (int i = 0; i < 15; i++) send_word(32'h130 + 32'(i), 4'hF, 1'b0);
    check("simul_pre_count", 32'(chunk_count), 32'd1);
    check("simul_pre_head", chunk_out[0], 32'h120);
    chunk_ready = 1'b1;
    send_word(32'h13F, 4'hF, 1'b0);
    chunk_ready = 1'b0;
    idle();
    check("simul_count", 32'(chunk_count), 32'd1);
    tick();
    check_chunk("simul_next", 32'h130, 16, 1'b0);
    consume_pulse();

    // Reset mid-chunk with one chunk held.
    for (int i = 0; i < 16; i++) send_word(32'h200 + 32'(i), 4'hF, 1'b0);
    for (int i = 0; i < 7; i++) send_word(32'h300 + 32'(i), 4'hF, 1'b0);
    idle();
    check("mid_valid", 32'(chunk_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(chunk_valid), 32'd0);
    check("mid_rst_count", 32'(chunk_count), 32'd0);
    check("mid_rst_words", 32'(chunk_words), 32'd0);
    check("mid_rst_last",  32'(chunk_last),  32'd0);
    check("mid_rst_data",  chunk_out[0], 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_tready", 32'(tready), 32'd1);
    tick();
    for (int i = 0; i < 16; i++) send_word(32'h400 + 32'(i), 4'hF, 1'b0);
    idle();
    tick();
    check_chunk("post_rst", 32'h400, 16, 1'b0);
    check("post_rst_count", 32'(chunk_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
